// File: rtl/game_pkg.sv
// Shared game types and constants for the state controller and scrolling layers.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam int MOVE_RATE_W = 4;
  localparam int SCORE_W     = 14;

  // Default scroll speeds, shared with the ground and obstacle layers.
  localparam int RATE_INIT_DFLT = 2;
  localparam int RATE_MAX_DFLT  = 8;

  // Saturating one-step increase of a scroll rate.
  function automatic logic [MOVE_RATE_W-1:0] rate_step_up(
    input logic [MOVE_RATE_W-1:0] rate,
    input logic [MOVE_RATE_W-1:0] ceiling
  );
    return (rate < ceiling) ? rate + 1'b1 : ceiling;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-flop synchroniser followed by a rising-edge pulse.
// Latency: pulse is visible 2 edges after the input is first captured.
// Backpressure: none; one-tick pulse per rise, consumers must take it that tick.
module btn_edge (
  input  logic clk_100,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync_a;
  logic sync_b;
  logic prev;

  // Synchronise the async button and remember last tick's level.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      prev   <= sync_b;
    end
  end

  assign rise = sync_b & ~prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Run/dead lifecycle, score, high score and scroll speed for the game tick.
// Latency: start 3 ticks after a button assertion; collision acts on the next edge.
// Backpressure: none; collision is sampled every tick, early restart presses are dropped.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_DIV  = 10,
  parameter int SPEED_STEP = 100,
  parameter int RATE_INIT  = RATE_INIT_DFLT,
  parameter int RATE_MAX   = RATE_MAX_DFLT,
  parameter int DEAD_HOLD  = 50,
  parameter int SCORE_MAX  = 9999
) (
  input  logic                   clk_100,
  input  logic                   rst_n,
  input  logic                   btn,
  input  logic                   collision,
  output logic                   is_living,
  output logic [MOVE_RATE_W-1:0] move_rate,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     hi_score,
  output logic                   game_over
);

  localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  // Hold counter must be able to hold DEAD_HOLD itself, since it saturates there.
  localparam int HOLD_W = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;

  localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [STEP_W-1:0]      STEP_LAST = STEP_W'(SPEED_STEP - 1);
  localparam logic [HOLD_W-1:0]      HOLD_LIM  = HOLD_W'(DEAD_HOLD);
  localparam logic [SCORE_W-1:0]     SCORE_TOP = SCORE_W'(SCORE_MAX);
  localparam logic [MOVE_RATE_W-1:0] RATE_TOP  = MOVE_RATE_W'(RATE_MAX);
  localparam logic [MOVE_RATE_W-1:0] RATE_BASE = MOVE_RATE_W'(RATE_INIT);

  logic rise;

  game_state_t           state_q,  state_d;
  logic [DIV_W-1:0]      div_q,    div_d;
  logic [STEP_W-1:0]     step_q,   step_d;
  logic [HOLD_W-1:0]     hold_q,   hold_d;
  logic [SCORE_W-1:0]    score_q,  score_d;
  logic [SCORE_W-1:0]    hi_q,     hi_d;
  logic [MOVE_RATE_W-1:0] rate_q,  rate_d;
  logic                  living_q, living_d;
  logic                  over_q,   over_d;
  logic                  start;

  btn_edge u_btn_edge (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .btn     (btn),
    .rise    (rise)
  );

  // State register plus all counters and registered outputs.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      score_q  <= '0;
      hi_q     <= '0;
      rate_q   <= '0;
      living_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      score_q  <= score_d;
      hi_q     <= hi_d;
      rate_q   <= rate_d;
      living_q <= living_d;
      over_q   <= over_d;
    end
  end

  // Next state, score divider, speed ramp, dead-hold timer and high score.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = step_q;
    hold_d  = hold_q;
    score_d = score_q;
    hi_d    = hi_q;
    rate_d  = rate_q;
    start   = 1'b0;

    case (state_q)
      IDLE: begin
        start = rise;
      end

      RUN: begin
        if (collision) begin
          // Collision beats a coincident score tick: freeze the pre-increment score.
          state_d = DEAD;
          rate_d  = '0;
          hold_d  = '0;
          if (score_q > hi_q) begin
            hi_d = score_q;
          end
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          // A saturated score also freezes the speed ramp.
          if (score_q != SCORE_TOP) begin
            score_d = score_q + 1'b1;
            if (step_q == STEP_LAST) begin
              step_d = '0;
              rate_d = rate_step_up(rate_q, RATE_TOP);
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DEAD: begin
        if (hold_q < HOLD_LIM) begin
          hold_d = hold_q + 1'b1;
        end
        // Presses before the hold expires are simply lost, never queued.
        start = rise && (hold_q >= HOLD_LIM);
      end

      default: begin
        state_d = IDLE;
        rate_d  = '0;
      end
    endcase

    if (start) begin
      state_d = RUN;
      score_d = '0;
      div_d   = '0;
      step_d  = '0;
      hold_d  = '0;
      rate_d  = RATE_BASE;
    end

    living_d = (state_d == RUN);
    over_d   = (state_d == DEAD);
  end

  assign is_living = living_q;
  assign game_over = over_q;
  assign move_rate = rate_q;
  assign score     = score_q;
  assign hi_score  = hi_q;

endmodule
